// File: rtl/des_decrypt_core.sv
// Iterative DES core that decrypts one 64-bit block with one Feistel round per clock.
// Defining DES_ENCRYPT_EN adds an 'encrypt' port that selects forward DES at accept.
module des_decrypt_core (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   input  logic [63:0] in_key,
`ifdef DES_ENCRYPT_EN
   input  logic        encrypt,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        busy
);

   localparam int unsigned OFF_IP  = 0;
   localparam int unsigned OFF_FP  = 64;
   localparam int unsigned OFF_E   = 128;
   localparam int unsigned OFF_P   = 176;
   localparam int unsigned OFF_PC1 = 208;
   localparam int unsigned OFF_PC2 = 264;
   localparam int unsigned PT_LEN  = 312;

   // Permutation tables, 1-based DES bit numbers (bit 1 = MSB of the source word).
   localparam logic [6:0] PT [PT_LEN] = '{
      // IP
      58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
      62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
      57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
      61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7,
      // FP
      40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
      38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
      36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
      34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25,
      // E
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
      12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
      22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1,
      // P
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25,
      // PC-1
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18, 10,  2,
      59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36, 63, 55, 47, 39,
      31, 23, 15,  7, 62, 54, 46, 38, 30, 22, 14,  6, 61, 53, 45, 37,
      29, 21, 13,  5, 28, 20, 12,  4,
      // PC-2
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
      26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
      51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   // sb1..sb8 packed as {box, row, column}.
   localparam logic [3:0] SB [512] = '{
      14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
      15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
      10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
       7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
       2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
      12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
       4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
      13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11
   };

   // Source is right-aligned in_w bits; result is right-aligned out_w bits.
   function automatic logic [63:0] perm(input logic [63:0] x, input int in_w,
                                        input int out_w, input int off);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++)
         if (i < out_w)
            y[6'(out_w - 1 - i)] = x[6'(in_w - int'(PT[9'(off + i)]))];
      return y;
   endfunction

   function automatic logic [31:0] feistel(input logic [31:0] rin, input logic [47:0] k);
      logic [47:0] x;
      logic [31:0] s;
      x = 48'(perm({32'b0, rin}, 32, 48, OFF_E)) ^ k;
      s = '0;
      for (int i = 0; i < 8; i++) begin
         logic [5:0] g;
         g = x[6'(47 - 6 * i) -: 6];
         s[5'(31 - 4 * i) -: 4] = SB[{3'(i), g[5], g[0], g[4:1]}];
      end
      return 32'(perm({32'b0, s}, 32, 32, OFF_P));
   endfunction

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   state_t      state;
   logic        idle_q;
   logic [31:0] l, r;
   logic [27:0] c, d;
   logic [3:0]  rnd;
`ifdef DES_ENCRYPT_EN
   logic        enc;
`else
   localparam logic enc = 1'b0;
`endif

   logic [4:0]  sidx;
   logic        single;
   logic [27:0] c_rl, d_rl, c_rr, d_rr, c_nx, d_nx;
   logic [47:0] kr;
   logic [31:0] f_out;
   logic [63:0] ip_w;
   logic [55:0] pc1_w;

   assign in_ready = idle_q & ~rst;

   // Round key and rotation for the round held in rnd.
   always_comb begin
      sidx   = enc ? 5'({1'b0, rnd}) + 5'd1 : 5'd16 - {1'b0, rnd};
      single = (sidx == 5'd1) || (sidx == 5'd2) || (sidx == 5'd9) || (sidx == 5'd16);
      c_rl   = single ? {c[26:0], c[27]} : {c[25:0], c[27:26]};
      d_rl   = single ? {d[26:0], d[27]} : {d[25:0], d[27:26]};
      c_rr   = single ? {c[0], c[27:1]} : {c[1:0], c[27:2]};
      d_rr   = single ? {d[0], d[27:1]} : {d[1:0], d[27:2]};
      kr     = enc ? 48'(perm({8'b0, c_rl, d_rl}, 56, 48, OFF_PC2))
                   : 48'(perm({8'b0, c, d}, 56, 48, OFF_PC2));
      c_nx   = enc ? c_rl : c_rr;
      d_nx   = enc ? d_rl : d_rr;
      f_out  = feistel(r, kr);
      ip_w   = perm(in_data, 64, 64, OFF_IP);
      pc1_w  = 56'(perm(in_key, 64, 56, OFF_PC1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idle_q    <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         l         <= '0;
         r         <= '0;
         c         <= '0;
         d         <= '0;
         rnd       <= '0;
`ifdef DES_ENCRYPT_EN
         enc       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  l      <= ip_w[63:32];
                  r      <= ip_w[31:0];
                  c      <= pc1_w[55:28];
                  d      <= pc1_w[27:0];
                  rnd    <= '0;
`ifdef DES_ENCRYPT_EN
                  enc    <= encrypt;
`endif
                  idle_q <= 1'b0;
                  busy   <= 1'b1;
                  state  <= ROUND;
               end
            end
            ROUND: begin
               l <= r;
               r <= l ^ f_out;
               c <= c_nx;
               d <= d_nx;
               if (rnd == 4'd15) begin
                  // Final round: swap halves into the inverse initial permutation.
                  out_data  <= perm({l ^ f_out, r}, 64, 64, OFF_FP);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  rnd <= rnd + 4'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  idle_q    <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state  <= IDLE;
               idle_q <= 1'b1;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_des_decrypt_core.sv
// Scoreboard bench for des_decrypt_core: directed DES vectors, stall, abort and back-to-back traffic.
module tb_des_decrypt_core;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic [63:0] in_key;
   logic        enc_sel;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        busy;

   des_decrypt_core dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_key   (in_key),
`ifdef DES_ENCRYPT_EN
      .encrypt  (enc_sel),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      int          acc;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_hs = -1;
   int          ov_rises = 0;
   logic        prev_ov = 1'b0;
   logic [63:0] held = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares each finished block against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (!prev_ov) begin
            ov_rises++;
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %h expected no output", out_data);
            end else begin
               mon_e = sb_q.pop_front();
               chk("out_data", out_data, mon_e.data);
               chk("latency", 64'(cyc + 1 - mon_e.acc), 64'd17);
            end
            held = out_data;
         end else begin
            chk("hold_stable", out_data, held);
         end
         if (out_ready) last_hs = cyc + 1;
      end
      prev_ov = out_valid && !rst;
   end

   task automatic send(input logic [63:0] k, input logic [63:0] din,
                       input logic [63:0] exp, output int acc);
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_key   = k;
      in_data  = din;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready 0 expected 1 within 100 cycles");
         in_valid = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc + 1;
      sb_q.push_back('{exp, acc});
      @(negedge clk);
      in_valid = 1'b0;
      in_key   = ~k;
      in_data  = ~din;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || out_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      end
   endtask

   localparam int NV = 5;
   logic [63:0] v_key [NV] = '{64'h133457799BBCDFF1, 64'h0E329232EA6D0D73, 64'h0000000000000000,
                               64'hFFFFFFFFFFFFFFFF, 64'h0123456789ABCDEF};
   logic [63:0] v_ct  [NV] = '{64'h85E813540F0AB405, 64'h0000000000000000, 64'h8CA64DE9C1B123A7,
                               64'h7359B2163E4EDC58, 64'h3FA40E8A984D4815};
   logic [63:0] v_pt  [NV] = '{64'h0123456789ABCDEF, 64'h8787878787878787, 64'h0000000000000000,
                               64'hFFFFFFFFFFFFFFFF, 64'h4E6F772069732074};

   initial begin
      int acc_a, acc_b, rises, n;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_key    = '0;
      enc_sel   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      rst = 1'b0;
      #1;
      chk("in_ready_after_rst", 64'(in_ready), 64'd1);

      // Directed vectors; in_data/in_key are inverted right after accept.
      for (int i = 0; i < NV; i++) begin
         send(v_key[i], v_ct[i], v_pt[i], acc_a);
         chk("busy_in_round", 64'(busy), 64'd1);
         chk("in_ready_in_round", 64'(in_ready), 64'd0);
         drain();
      end

      // Consumer stall with ignored in_valid pulses.
      out_ready = 1'b0;
      send(v_key[1], v_ct[1], v_pt[1], acc_a);
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("stall_reached_done", 64'(out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2) == 0;
         in_data  = 64'(i) * 64'h1111111111111111;
         in_key   = v_key[0];
         @(negedge clk);
         chk("stall_in_ready", 64'(in_ready), 64'd0);
         chk("stall_out_valid", 64'(out_valid), 64'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();
      repeat (3) @(negedge clk);
      chk("idle_after_stall", 64'(in_ready), 64'd1);

      // Reset while round 8 is in flight.
      send(v_key[2], v_ct[2], v_pt[2], acc_a);
      repeat (7) @(negedge clk);
      rises = ov_rises;
      rst = 1'b1;
      sb_q.delete();
      #1;
      chk("abort_in_ready", 64'(in_ready), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_out_data", out_data, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_in_ready_after", 64'(in_ready), 64'd1);
      repeat (25) @(negedge clk);
      chk("abort_no_output", 64'(ov_rises - rises), 64'd0);
      send(v_key[0], v_ct[0], v_pt[0], acc_a);
      drain();

      // Back-to-back: second block waits with in_valid high.
      send(v_key[3], v_ct[3], v_pt[3], acc_a);
      send(v_key[4], v_ct[4], v_pt[4], acc_b);
      chk("b2b_accept_gap", 64'(acc_b - last_hs), 64'd1);
      drain();

`ifdef DES_ENCRYPT_EN
      enc_sel = 1'b1;
      send(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, acc_a);
      drain();
      enc_sel = 1'b0;
      send(v_key[1], v_ct[1], v_pt[1], acc_a);
      drain();
`endif

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
